// File: rtl/gpio_port.sv
// Register-mapped bidirectional GPIO on the KCPSM port bus: output/direction latches,
// a pad synchroniser and per-bit edge-detect interrupts with enable and polarity.
module gpio_port #(
  parameter int         WIDTH     = 16,
  parameter logic [7:0] BASE_ADDR = 8'h40
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] io_pad,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic             irq
);

  localparam int LANES = WIDTH / 8;

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR   = 3'd1;
  localparam logic [2:0] REG_IN    = 3'd2;
  localparam logic [2:0] REG_IEN   = 3'd3;
  localparam logic [2:0] REG_IPOL  = 3'd4;
  localparam logic [2:0] REG_ISTAT = 3'd5;

  logic [WIDTH-1:0] out_reg, dir_reg, ien_reg, ipol_reg, istat_reg;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] lane_mask, wr_word, rise, fall, ev, clr_mask, rd_vec;
  logic             selected, wr_en;
  logic [2:0]       reg_idx;
  logic [1:0]       lane;
  logic [7:0]       rd_next;
  logic             unused_read_strobe;

  assign selected           = (port_id[7:5] == BASE_ADDR[7:5]);
  assign reg_idx            = port_id[4:2];
  assign lane               = port_id[1:0];
  assign wr_en              = selected & write_strobe;
  assign wr_word            = {LANES{wr_data}};
  assign unused_read_strobe = read_strobe;

  // Lanes beyond WIDTH leave the mask empty, so writes to them change nothing
  always_comb begin
    lane_mask = '0;
    for (int l = 0; l < LANES; l++)
      if (lane == 2'(l)) lane_mask[l*8 +: 8] = 8'hFF;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign io_pad[i] = dir_reg[i] ? 1'bz : out_reg[i];
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign ev       = ien_reg & ((ipol_reg & rise) | (~ipol_reg & fall));
  assign clr_mask = (wr_en && reg_idx == REG_ISTAT) ? (wr_word & lane_mask) : '0;

  // Control registers; a new event on a bit overrides a simultaneous W1C of it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg   <= '0;
      dir_reg   <= '1;
      ien_reg   <= '0;
      ipol_reg  <= '1;
      istat_reg <= '0;
    end else begin
      if (wr_en) begin
        case (reg_idx)
          REG_OUT:  out_reg  <= (out_reg  & ~lane_mask) | (wr_word & lane_mask);
          REG_DIR:  dir_reg  <= (dir_reg  & ~lane_mask) | (wr_word & lane_mask);
          REG_IEN:  ien_reg  <= (ien_reg  & ~lane_mask) | (wr_word & lane_mask);
          REG_IPOL: ipol_reg <= (ipol_reg & ~lane_mask) | (wr_word & lane_mask);
          default:  ;
        endcase
      end
      istat_reg <= (istat_reg & ~clr_mask) | ev;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= io_pad;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    case (reg_idx)
      REG_OUT:   rd_vec = out_reg;
      REG_DIR:   rd_vec = dir_reg;
      REG_IN:    rd_vec = s2;
      REG_IEN:   rd_vec = ien_reg;
      REG_IPOL:  rd_vec = ipol_reg;
      REG_ISTAT: rd_vec = istat_reg;
      default:   rd_vec = '0;
    endcase
    rd_next = 8'h00;
    for (int l = 0; l < LANES; l++)
      if (lane == 2'(l)) rd_next = rd_vec[l*8 +: 8];
    if (!selected) rd_next = 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
      irq     <= 1'b0;
    end else begin
      rd_data <= rd_next;
      irq     <= |(istat_reg & ien_reg);
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed register/interrupt scenarios followed by random bus and
// pad traffic, all checked against a cycle-level reference model of the register map.
module tb_gpio_port;

  localparam int WIDTH = 16;

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  wire  [WIDTH-1:0] io_pad;
  logic [7:0]       port_id      = 8'h00;
  logic             write_strobe = 1'b0;
  logic             read_strobe  = 1'b0;
  logic [7:0]       wr_data      = 8'h00;
  logic [7:0]       rd_data;
  logic             irq;

  logic [WIDTH-1:0] drv_en  = '1;
  logic [WIDTH-1:0] drv_val = '0;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] m_out, m_dir, m_ien, m_ipol, m_istat;
  logic [WIDTH-1:0] samp_q[$];
  logic [7:0]       m_rd;
  logic             m_irq;

  always #5 clk = ~clk;

  for (genvar i = 0; i < WIDTH; i++) begin : g_drv
    assign io_pad[i] = drv_en[i] ? drv_val[i] : 1'bz;
  end

  gpio_port #(.WIDTH(WIDTH), .BASE_ADDR(8'h40)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_pad       (io_pad),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .irq          (irq)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out   = '0;
    m_dir   = '1;
    m_ien   = '0;
    m_ipol  = '1;
    m_istat = '0;
    samp_q  = {16'h0, 16'h0, 16'h0};
    m_rd    = 8'h00;
    m_irq   = 1'b0;
    drv_en  = '1;
  endtask

  // What the pads should carry: the bench drives input bits, the DUT drives output bits
  function automatic logic [15:0] pad_model();
    return (m_dir & drv_val) | (~m_dir & m_out);
  endfunction

  function automatic logic [7:0] read_model(input logic [7:0] pid);
    logic [15:0] v;
    int          ln;
    if (pid[7:5] != 3'b010) return 8'h00;
    ln = int'(pid[1:0]);
    if (ln >= WIDTH / 8) return 8'h00;
    case (pid[4:2])
      3'd0:    v = m_out;
      3'd1:    v = m_dir;
      3'd2:    v = samp_q[1];
      3'd3:    v = m_ien;
      3'd4:    v = m_ipol;
      3'd5:    v = m_istat;
      default: v = '0;
    endcase
    return v[ln*8 +: 8];
  endfunction

  // Advance the model by one clock from the current inputs, then check all outputs
  task automatic clock_cycle();
    logic [15:0] pad, rise, fall, ev, clr, mask, wv;
    logic [7:0]  nrd;
    logic        nirq;
    int          ln;
    pad  = pad_model();
    rise = samp_q[1] & ~samp_q[2];
    fall = ~samp_q[1] & samp_q[2];
    ev   = m_ien & ((m_ipol & rise) | (~m_ipol & fall));
    nrd  = read_model(port_id);
    nirq = |(m_istat & m_ien);
    clr  = '0;
    ln   = int'(port_id[1:0]);
    if (write_strobe && port_id[7:5] == 3'b010 && ln < WIDTH / 8) begin
      mask = 16'h00FF << (ln * 8);
      wv   = {2{wr_data}};
      case (port_id[4:2])
        3'd0:    m_out  = (m_out  & ~mask) | (wv & mask);
        3'd1:    m_dir  = (m_dir  & ~mask) | (wv & mask);
        3'd3:    m_ien  = (m_ien  & ~mask) | (wv & mask);
        3'd4:    m_ipol = (m_ipol & ~mask) | (wv & mask);
        3'd5:    clr    = wv & mask;
        default: ;
      endcase
    end
    m_istat = (m_istat & ~clr) | ev;
    samp_q.push_front(pad);
    void'(samp_q.pop_back());
    m_rd  = nrd;
    m_irq = nirq;
    @(posedge clk);
    #1;
    drv_en = m_dir;
    #1;
    check_val("rd_data", {8'h00, rd_data}, {8'h00, m_rd});
    check_val("irq", {15'h0, irq}, {15'h0, m_irq});
    check_val("io_pad", io_pad, pad_model());
  endtask

  task automatic idle(input int n);
    port_id      = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    repeat (n) clock_cycle();
  endtask

  task automatic bus_write(input logic [7:0] pid, input logic [7:0] data);
    port_id      = pid;
    wr_data      = data;
    write_strobe = 1'b1;
    read_strobe  = 1'b0;
    clock_cycle();
    write_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] pid, input logic [7:0] exp, input string tag);
    port_id     = pid;
    read_strobe = 1'b1;
    clock_cycle();
    read_strobe = 1'b0;
    check_val(tag, {8'h00, rd_data}, {8'h00, exp});
  endtask

  initial begin
    model_reset();
    drv_val = 16'h00C0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("reset_rd_data", {8'h00, rd_data}, 16'h0000);
    check_val("reset_irq", {15'h0, irq}, 16'h0000);
    check_val("reset_pads_tristated", io_pad, drv_val);

    // Reset values readable through the bus
    bus_read(8'h44, 8'hFF, "dir_lane0_reset");
    bus_read(8'h51, 8'hFF, "ipol_lane1_reset");

    // Lower nibble drives, upper nibble of lane 0 is an input, lane 1 drives
    bus_write(8'h44, 8'hF0);
    bus_write(8'h45, 8'h00);
    bus_write(8'h40, 8'hA5);
    check_val("pad_lo_driven", {12'h0, io_pad[3:0]}, 16'h0005);
    check_val("pad_hi_driven", {8'h00, io_pad[15:8]}, 16'h0000);
    port_id = 8'h48;
    repeat (3) clock_cycle();
    check_val("in_readback", {8'h00, rd_data}, 16'h00C5);

    // Rising-edge interrupt on bit 4
    bus_write(8'h4C, 8'h10);
    bus_write(8'h50, 8'h10);
    idle(3);
    drv_val[4] = 1'b1;
    idle(2);
    check_val("irq_before_set", {15'h0, irq}, 16'h0000);
    idle(1);
    check_val("irq_at_set_edge", {15'h0, irq}, 16'h0000);
    idle(1);
    check_val("irq_raised", {15'h0, irq}, 16'h0001);
    bus_read(8'h54, 8'h10, "istat_rise");
    bus_write(8'h54, 8'h10);
    idle(1);
    check_val("irq_cleared", {15'h0, irq}, 16'h0000);

    // Falling polarity; bit 5 is never enabled so its edges must be dropped
    bus_write(8'h4C, 8'h00);
    drv_val[4] = 1'b0;
    idle(4);
    bus_write(8'h50, 8'h00);
    bus_write(8'h4C, 8'h10);
    drv_val[4] = 1'b1;
    drv_val[5] = 1'b1;
    idle(4);
    bus_read(8'h54, 8'h00, "istat_rise_ignored");
    drv_val[4] = 1'b0;
    drv_val[5] = 1'b0;
    idle(4);
    bus_read(8'h54, 8'h10, "istat_fall");

    // Event arriving on the same edge as its W1C keeps the bit set
    drv_val[4] = 1'b1;
    idle(4);
    drv_val[4] = 1'b0;
    idle(2);
    bus_write(8'h54, 8'h10);
    bus_read(8'h54, 8'h10, "istat_set_wins");
    check_val("irq_held", {15'h0, irq}, 16'h0001);

    // Asynchronous reset mid-cycle while pads are driven and irq is high
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("async_irq_drop", {15'h0, irq}, 16'h0000);
    check_val("async_rd_clear", {8'h00, rd_data}, 16'h0000);
    check_val("async_pads_tristated", io_pad, drv_val);
    #1;
    reset = 1'b0;

    // Unimplemented lane and foreign block address
    bus_write(8'h43, 8'hFF);
    bus_read(8'h43, 8'h00, "lane3_reads_zero");
    bus_write(8'h60, 8'h5A);
    bus_read(8'h40, 8'h00, "foreign_write_ignored");
    bus_read(8'h44, 8'hFF, "dir_after_foreign");

    // Random bus and pad traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) port_id = 8'($urandom);
      else port_id = {3'b010, 5'($urandom)};
      write_strobe = ($urandom_range(0, 2) == 0);
      read_strobe  = !write_strobe;
      wr_data      = 8'($urandom);
      if ($urandom_range(0, 3) == 0) drv_val = 16'($urandom);
      clock_cycle();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
